mirror_check: RTL

MIRROR_CHECK -- requirements
Module: mirror_check

---
 rtl/mirror_check.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/mirror_check.sv
// mirror_check: splits a decimal number of known digit count into its upper
// and lower digit halves. It uses an iterative power-of-ten build and a
// restoring divider, then reports whether the two halves are numerically equal.
module mirror_check #(
    parameter int DATA_W = 34,
    parameter int HALF_W = 17
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              start,
    input  logic [DATA_W-1:0] in,
    input  logic [3:0]        len,
    output logic              busy,
    output logic              done,
    output logic              match,
    output logic [HALF_W-1:0] hi,
    output logic [HALF_W-1:0] lo
);

    localparam int REM_W = DATA_W + 1;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        POW  = 3'd1,
        DIV  = 3'd2,
        CMP  = 3'd3,
        DONE = 3'd4
    } state_t;

    state_t            state, state_n;
    logic [REM_W-1:0]  p, p_n;
    logic [REM_W-1:0]  rem, rem_n;
    logic [DATA_W-1:0] quo, quo_n;
    logic [5:0]        cnt, cnt_n;
    logic [HALF_W-1:0] hi_n, lo_n;
    logic              match_n, done_n, busy_n;
    logic              len_ok;
    logic [REM_W-1:0]  shifted;
    logic              ge;

    // multiply by ten using only shifts and an add
    function automatic logic [REM_W-1:0] times_ten(input logic [REM_W-1:0] v);
        return (v << 3) + (v << 1);
    endfunction

    // one restoring-division step: shift in the next dividend bit and
    // subtract the divisor only if the result would stay non-negative
    function automatic logic [REM_W-1:0] div_step(input logic [REM_W-1:0] r,
                                                  input logic [REM_W-1:0] d,
                                                  input logic             take);
        return take ? (r - d) : r;
    endfunction

    // a number can only be split evenly when it has an even, non-zero digit
    // count within range; a zero value carries no digits to mirror
    assign len_ok = (len[0] == 1'b0) && (len >= 4'd2) && (len <= 4'd10) &&
                    (in != '0);

    // state register and all datapath/output registers, frozen when en=0
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            p     <= '0;
            rem   <= '0;
            quo   <= '0;
            cnt   <= '0;
            hi    <= '0;
            lo    <= '0;
            match <= 1'b0;
            done  <= 1'b0;
            busy  <= 1'b0;
        end else if (en) begin
            state <= state_n;
            p     <= p_n;
            rem   <= rem_n;
            quo   <= quo_n;
            cnt   <= cnt_n;
            hi    <= hi_n;
            lo    <= lo_n;
            match <= match_n;
            done  <= done_n;
            busy  <= busy_n;
        end
    end

    // next-state and next-register values for every state
    always_comb begin
        state_n = state;
        p_n     = p;
        rem_n   = rem;
        quo_n   = quo;
        cnt_n   = cnt;
        hi_n    = hi;
        lo_n    = lo;
        match_n = match;
        done_n  = 1'b0;
        shifted = {rem[REM_W-2:0], quo[DATA_W-1]};
        ge      = (shifted >= p);

        case (state)
            IDLE: begin
                if (start) begin
                    quo_n   = in;
                    rem_n   = '0;
                    p_n     = {{(REM_W-1){1'b0}}, 1'b1};
                    hi_n    = '0;
                    lo_n    = '0;
                    match_n = 1'b0;
                    if (len_ok) begin
                        state_n = POW;
                        cnt_n   = {3'b000, len[3:1]};
                    end else begin
                        state_n = DONE;
                        cnt_n   = '0;
                        done_n  = 1'b1;
                    end
                end
            end
            POW: begin
                p_n   = times_ten(p);
                cnt_n = cnt - 6'd1;
                if (cnt == 6'd1) begin
                    state_n = DIV;
                    cnt_n   = 6'(DATA_W);
                    rem_n   = '0;
                end
            end
            DIV: begin
                rem_n = div_step(shifted, p, ge);
                quo_n = {quo[DATA_W-2:0], ge};
                cnt_n = cnt - 6'd1;
                if (cnt == 6'd1) begin
                    state_n = CMP;
                end
            end
            CMP: begin
                hi_n    = quo[HALF_W-1:0];
                lo_n    = rem[HALF_W-1:0];
                match_n = ({1'b0, quo} == rem);
                state_n = DONE;
                done_n  = 1'b1;
            end
            DONE: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase

        busy_n = (state_n != IDLE);
    end

endmodule
